// File: rtl/clap_detector_pkg.sv
// -----------------------------------------------------------------------------
// clap_detector_pkg
// Shared definitions for the clap detector:
//   - detector state encodings (also exported on detector_state for LEDs),
//   - default loud threshold and frame-count constants, shared with top2 and
//     the energy stage,
//   - clogb2 / max4 helpers used to size the frame counters.
// -----------------------------------------------------------------------------
package clap_detector_pkg;

    // Encodings are fixed: software and LED decoding depend on these values.
    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_CLAP1   = 3'd1,
        ST_GAP     = 3'd2,
        ST_CLAP2   = 3'd3,
        ST_HOLDOFF = 3'd4,
        ST_NOISE   = 3'd5
    } state_t;

    localparam int          DEF_ENERGY_WIDTH    = 32;
    localparam logic [31:0] DEF_THRESHOLD       = 32'h0010_0000;
    localparam int          DEF_CLAP_MAX_FRAMES = 6;
    localparam int          DEF_MIN_GAP_FRAMES  = 3;
    localparam int          DEF_MAX_GAP_FRAMES  = 40;
    localparam int          DEF_HOLDOFF_FRAMES  = 64;

    // Smallest number of bits r with 2**r >= value (at least 1).
    function automatic int clogb2(input int value);
        int result;
        result = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                result = i + 1;
            end
        end
        if (result == 0) begin
            result = 1;
        end
        return result;
    endfunction

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

endpackage

// File: rtl/clap_detector_frame_counter.sv
// -----------------------------------------------------------------------------
// clap_detector_frame_counter
// Frame-based counter shared by the clap length, gap, holdoff and noise-quiet
// counters. Every operation is qualified by the frame strobe so the counter
// advances in energy frames, never in raw clock cycles.
//
// Ports:
//   clock     - system clock
//   reset     - asynchronous, active-high reset (count -> 0)
//   frame     - energy_ready strobe; no change happens without it
//   clear     - count <= 0            (highest priority)
//   load_one  - count <= 1
//   inc       - count <= count + 1    (lowest priority)
//   limit     - terminal-count value to compare against
//   count     - current count
//   at_limit  - count == limit
// The owning FSM never requests an increment past the widest limit, so no
// saturation logic is needed here.
// -----------------------------------------------------------------------------
module clap_detector_frame_counter #(
    parameter int CNT_W = 6
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             frame,
    input  logic             clear,
    input  logic             load_one,
    input  logic             inc,
    input  logic [CNT_W-1:0] limit,
    output logic [CNT_W-1:0] count,
    output logic             at_limit
);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            count <= '0;
        end else if (frame) begin
            if (clear) begin
                count <= '0;
            end else if (load_one) begin
                count <= CNT_W'(1);
            end else if (inc) begin
                count <= count + CNT_W'(1);
            end
        end
    end

    assign at_limit = (count == limit);

endmodule

// File: rtl/clap_detector.sv
// -----------------------------------------------------------------------------
// clap_detector
// Recognises a "clap-clap" pattern in the per-window energy stream: two short
// loud bursts separated by a bounded quiet gap. Each recognised pattern
// toggles the light state; a holdoff window then ignores further claps.
//
// Ports:
//   clock          - system clock
//   reset          - asynchronous, active-high reset (fully abortive)
//   energy         - energy of the latest window, valid while energy_ready = 1
//   energy_ready   - single-cycle strobe marking one new frame
//   toglite_state  - registered light state
//   toggle_pulse   - one-cycle pulse on the edge the light toggles
//   detector_state - current FSM state (state_t encoding) for debug/LEDs
//
// Handshake: energy_ready is a frame strobe with no back-pressure. Every clock
// edge that sees energy_ready = 1 consumes exactly one frame (back-to-back
// high cycles are separate frames); with energy_ready = 0 everything holds,
// except toggle_pulse, which always clears one cycle after it is raised.
// -----------------------------------------------------------------------------
module clap_detector
    import clap_detector_pkg::*;
#(
    parameter int                      ENERGY_WIDTH    = DEF_ENERGY_WIDTH,
    parameter logic [ENERGY_WIDTH-1:0] THRESHOLD       = ENERGY_WIDTH'(DEF_THRESHOLD),
    parameter int                      CLAP_MAX_FRAMES = DEF_CLAP_MAX_FRAMES,
    parameter int                      MIN_GAP_FRAMES  = DEF_MIN_GAP_FRAMES,
    parameter int                      MAX_GAP_FRAMES  = DEF_MAX_GAP_FRAMES,
    parameter int                      HOLDOFF_FRAMES  = DEF_HOLDOFF_FRAMES
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic [ENERGY_WIDTH-1:0] energy,
    input  logic                    energy_ready,
    output logic                    toglite_state,
    output logic                    toggle_pulse,
    output logic [2:0]              detector_state
);

    // Wide enough for every value a counter can hold (len and gap reach their
    // limits, the quiet count reaches MIN_GAP_FRAMES, hcnt stops one short).
    localparam int CNT_W = clogb2(max4(HOLDOFF_FRAMES, MAX_GAP_FRAMES + 1,
                                       CLAP_MAX_FRAMES + 1, MIN_GAP_FRAMES + 1));

    localparam logic [CNT_W-1:0] LEN_LAST   = CNT_W'(CLAP_MAX_FRAMES);
    localparam logic [CNT_W-1:0] GAP_LAST   = CNT_W'(MAX_GAP_FRAMES);
    localparam logic [CNT_W-1:0] GAP_MIN    = CNT_W'(MIN_GAP_FRAMES);
    localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(HOLDOFF_FRAMES - 1);
    // NOISE leaves on the quiet frame that brings qcnt up to MIN_GAP_FRAMES,
    // i.e. when the current count is one below it.
    localparam logic [CNT_W-1:0] QUIET_LAST = CNT_W'(MIN_GAP_FRAMES - 1);

    state_t state;
    logic   loud;

    logic             len_load, len_inc, len_at_last;
    logic             gap_load, gap_inc, gap_at_last;
    logic             hold_clear, hold_inc, hold_at_last;
    logic             quiet_clear, quiet_inc, quiet_at_last;
    logic [CNT_W-1:0] len_cnt, gap_cnt, hold_cnt, quiet_cnt;
    logic             gap_met_min;
    logic             unused_cnt_bits;

    assign loud        = (energy >= THRESHOLD);
    assign gap_met_min = (gap_cnt >= GAP_MIN);

    // Only the gap needs a magnitude compare; the others use terminal counts.
    assign unused_cnt_bits = ^{len_cnt, hold_cnt, quiet_cnt};

    // -------------------------------------------------------------------------
    // Counter controls, derived from the state about to be left and the frame
    // classification. The counters themselves only act on energy_ready.
    // -------------------------------------------------------------------------
    always_comb begin
        len_load    = 1'b0;
        len_inc     = 1'b0;
        gap_load    = 1'b0;
        gap_inc     = 1'b0;
        hold_clear  = 1'b0;
        hold_inc    = 1'b0;
        quiet_clear = 1'b0;
        quiet_inc   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (loud) len_load = 1'b1;
            end
            ST_CLAP1, ST_CLAP2: begin
                if (!loud) begin
                    if (state == ST_CLAP1) gap_load   = 1'b1;
                    else                   hold_clear = 1'b1;
                end else if (len_at_last) begin
                    quiet_clear = 1'b1;
                end else begin
                    len_inc = 1'b1;
                end
            end
            ST_GAP: begin
                if (loud) begin
                    if (gap_met_min) len_load    = 1'b1;
                    else             quiet_clear = 1'b1;
                end else if (!gap_at_last) begin
                    gap_inc = 1'b1;
                end
            end
            ST_HOLDOFF: begin
                // On the last holdoff frame hcnt is parked at 0 instead of
                // stepping past its limit.
                if (hold_at_last) begin
                    hold_clear = 1'b1;
                    if (loud) quiet_clear = 1'b1;
                end else begin
                    hold_inc = 1'b1;
                end
            end
            ST_NOISE: begin
                if (loud) quiet_clear = 1'b1;
                else      quiet_inc   = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // FSM with registered outputs.
    // -------------------------------------------------------------------------
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            toglite_state <= 1'b0;
            toggle_pulse  <= 1'b0;
        end else begin
            toggle_pulse <= 1'b0;
            if (energy_ready) begin
                case (state)
                    ST_IDLE: begin
                        if (loud) state <= ST_CLAP1;
                    end
                    ST_CLAP1: begin
                        if (!loud)            state <= ST_GAP;
                        else if (len_at_last) state <= ST_NOISE;
                    end
                    ST_GAP: begin
                        if (loud)             state <= gap_met_min ? ST_CLAP2 : ST_NOISE;
                        else if (gap_at_last) state <= ST_IDLE;
                    end
                    ST_CLAP2: begin
                        if (!loud) begin
                            // First quiet frame after clap 2 completes the pattern.
                            state         <= ST_HOLDOFF;
                            toglite_state <= ~toglite_state;
                            toggle_pulse  <= 1'b1;
                        end else if (len_at_last) begin
                            state <= ST_NOISE;
                        end
                    end
                    ST_HOLDOFF: begin
                        if (hold_at_last) state <= loud ? ST_NOISE : ST_IDLE;
                    end
                    ST_NOISE: begin
                        if (!loud && quiet_at_last) state <= ST_IDLE;
                    end
                    default: begin
                        state <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign detector_state = state;

    // -------------------------------------------------------------------------
    // Frame counters.
    // -------------------------------------------------------------------------
    clap_detector_frame_counter #(.CNT_W(CNT_W)) u_len_cnt (
        .clock    (clock),
        .reset    (reset),
        .frame    (energy_ready),
        .clear    (1'b0),
        .load_one (len_load),
        .inc      (len_inc),
        .limit    (LEN_LAST),
        .count    (len_cnt),
        .at_limit (len_at_last)
    );

    clap_detector_frame_counter #(.CNT_W(CNT_W)) u_gap_cnt (
        .clock    (clock),
        .reset    (reset),
        .frame    (energy_ready),
        .clear    (1'b0),
        .load_one (gap_load),
        .inc      (gap_inc),
        .limit    (GAP_LAST),
        .count    (gap_cnt),
        .at_limit (gap_at_last)
    );

    clap_detector_frame_counter #(.CNT_W(CNT_W)) u_hold_cnt (
        .clock    (clock),
        .reset    (reset),
        .frame    (energy_ready),
        .clear    (hold_clear),
        .load_one (1'b0),
        .inc      (hold_inc),
        .limit    (HOLD_LAST),
        .count    (hold_cnt),
        .at_limit (hold_at_last)
    );

    clap_detector_frame_counter #(.CNT_W(CNT_W)) u_quiet_cnt (
        .clock    (clock),
        .reset    (reset),
        .frame    (energy_ready),
        .clear    (quiet_clear),
        .load_one (1'b0),
        .inc      (quiet_inc),
        .limit    (QUIET_LAST),
        .count    (quiet_cnt),
        .at_limit (quiet_at_last)
    );

endmodule

// File: tb/tb_clap_detector.sv
// -----------------------------------------------------------------------------
// tb_clap_detector
// Directed test-plan scenarios followed by randomized burst/gap traffic.
// A reference model written in terms of loud runs and quiet runs predicts the
// outputs after each frame; the driver pushes that prediction into exp_q and
// an independent monitor pops and compares on every frame edge. Cycles with
// no frame check that toggle_pulse has cleared.
// -----------------------------------------------------------------------------
module tb_clap_detector;

    localparam int          EW     = 32;
    localparam logic [31:0] THR    = 32'd100;
    localparam int          CMAX   = 6;
    localparam int          GMIN   = 3;
    localparam int          GMAX   = 40;
    localparam int          HOLD   = 64;

    logic          clock;
    logic          reset;
    logic [EW-1:0] energy;
    logic          energy_ready;
    logic          toglite_state;
    logic          toggle_pulse;
    logic [2:0]    detector_state;

    int checks = 0;
    int errors = 0;

    // {toglite_state, toggle_pulse, detector_state}
    logic [4:0] exp_q[$];

    clap_detector #(
        .ENERGY_WIDTH    (EW),
        .THRESHOLD       (THR),
        .CLAP_MAX_FRAMES (CMAX),
        .MIN_GAP_FRAMES  (GMIN),
        .MAX_GAP_FRAMES  (GMAX),
        .HOLDOFF_FRAMES  (HOLD)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .energy         (energy),
        .energy_ready   (energy_ready),
        .toglite_state  (toglite_state),
        .toggle_pulse   (toggle_pulse),
        .detector_state (detector_state)
    );

    // ---------------------------------------------------------------- clock
    initial clock = 1'b0;
    always #5 clock = ~clock;

    // ---------------------------------------------------------------- model
    // Phases: 0 waiting, 1 first burst, 2 quiet gap, 3 second burst,
    // 4 holdoff, 5 noise recovery.
    int m_phase, m_loud_run, m_quiet_run, m_hold_seen;
    bit m_light;

    function automatic void model_reset();
        m_phase = 0; m_loud_run = 0; m_quiet_run = 0; m_hold_seen = 0; m_light = 1'b0;
    endfunction

    function automatic logic [4:0] model_frame(input logic [EW-1:0] e);
        bit is_loud;
        bit pulse;
        is_loud = (e >= THR);
        pulse   = 1'b0;
        case (m_phase)
            0: if (is_loud) begin m_phase = 1; m_loud_run = 1; end
            1, 3: begin
                if (!is_loud) begin
                    if (m_phase == 1) begin m_phase = 2; m_quiet_run = 1; end
                    else begin
                        m_phase = 4; m_hold_seen = 0; m_light = !m_light; pulse = 1'b1;
                    end
                end else if (m_loud_run + 1 > CMAX) begin
                    m_phase = 5; m_quiet_run = 0;
                end else m_loud_run = m_loud_run + 1;
            end
            2: begin
                if (is_loud) begin
                    if (m_quiet_run >= GMIN) begin m_phase = 3; m_loud_run = 1; end
                    else begin m_phase = 5; m_quiet_run = 0; end
                end else if (m_quiet_run + 1 > GMAX) m_phase = 0;
                else m_quiet_run = m_quiet_run + 1;
            end
            4: begin
                // This is holdoff frame number m_hold_seen+1 of HOLD.
                if (m_hold_seen == HOLD - 1) begin
                    if (is_loud) begin m_phase = 5; m_quiet_run = 0; end
                    else m_phase = 0;
                end else m_hold_seen = m_hold_seen + 1;
            end
            default: begin
                if (is_loud) m_quiet_run = 0;
                else begin
                    m_quiet_run = m_quiet_run + 1;
                    if (m_quiet_run == GMIN) m_phase = 0;
                end
            end
        endcase
        return {m_light, pulse, 3'(m_phase)};
    endfunction

    // ---------------------------------------------------------------- driver
    // Tasks are entered and left on a falling edge.
    task automatic send_frame(input logic [EW-1:0] e);
        energy       = e;
        energy_ready = 1'b1;
        exp_q.push_back(model_frame(e));
        @(negedge clock);
    endtask

    task automatic idle_cycles(input int n);
        if (n > 0) begin
            energy_ready = 1'b0;
            energy       = $urandom;   // must be ignored
            repeat (n) @(negedge clock);
        end
    endtask

    function automatic logic [EW-1:0] rnd_loud();
        if ($urandom_range(0, 7) == 0) return THR;
        return EW'($urandom_range(101, 5000));
    endfunction

    function automatic logic [EW-1:0] rnd_quiet();
        if ($urandom_range(0, 7) == 0) return THR - 1;
        return EW'($urandom_range(0, 99));
    endfunction

    task automatic send_pattern(input int loud_n, input int quiet_n);
        for (int i = 0; i < loud_n; i++) begin
            send_frame(rnd_loud());
            idle_cycles($urandom_range(0, 2));
        end
        for (int i = 0; i < quiet_n; i++) begin
            send_frame(rnd_quiet());
            idle_cycles($urandom_range(0, 2));
        end
    endtask

    // The test-plan double clap: 0,0,200,200,0,0,0,0,200,0
    task automatic double_clap();
        send_frame(0); send_frame(0); send_frame(200); send_frame(200);
        send_frame(0); send_frame(0); send_frame(0); send_frame(0);
        send_frame(200); send_frame(0);
    endtask

    task automatic quiet_frames(input int n);
        for (int i = 0; i < n; i++) send_frame(0);
    endtask

    // Direct check against a value fixed by the test plan.
    task automatic expect_now(input string name, input logic [4:0] got, input logic [4:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s: got %b want %b", name, got, want);
        end
    endtask

    function automatic logic [4:0] outs();
        return {toglite_state, toggle_pulse, detector_state};
    endfunction

    // ---------------------------------------------------------------- monitor
    initial begin : monitor
        logic       frame_seen;
        logic [4:0] want;
        forever begin
            @(posedge clock);
            frame_seen = energy_ready && !reset;
            #2;
            if (!reset) begin
                checks++;
                if (frame_seen) begin
                    if (exp_q.size() == 0) begin
                        errors++;
                        $display("FAIL frame_unexpected: got %b with empty queue", outs());
                    end else begin
                        want = exp_q.pop_front();
                        if (outs() !== want) begin
                            errors++;
                            $display("FAIL frame_outputs at %0t: got %b want %b", $time, outs(), want);
                        end
                    end
                end else if (toggle_pulse !== 1'b0) begin
                    errors++;
                    $display("FAIL pulse_clear at %0t: got %b want 0", $time, toggle_pulse);
                end
            end
        end
    end

    // ---------------------------------------------------------------- stimulus
    initial begin : stimulus
        int wait_cycles;
        reset        = 1'b1;
        energy       = '0;
        energy_ready = 1'b0;
        model_reset();
        repeat (3) @(negedge clock);
        expect_now("reset_outputs", outs(), 5'b00_000);
        reset = 1'b0;
        @(negedge clock);

        // Double clap: toggles on the final frame.
        double_clap();
        expect_now("double_clap", outs(), 5'b11_100);
        quiet_frames(HOLD);
        expect_now("after_holdoff", outs(), 5'b10_000);

        // Gap too short.
        send_frame(200); send_frame(0); send_frame(200);
        expect_now("short_gap_noise", outs(), 5'b10_101);
        quiet_frames(2);
        expect_now("short_gap_still_noise", outs(), 5'b10_101);
        quiet_frames(1);
        expect_now("short_gap_idle", outs(), 5'b10_000);

        // Gap timeout: burst, 41 quiet frames, then a burst that only starts clap 1.
        send_frame(200);
        quiet_frames(GMAX);
        expect_now("gap_at_max", outs(), 5'b10_010);
        quiet_frames(1);
        expect_now("gap_timeout", outs(), 5'b10_000);
        send_frame(200);
        expect_now("late_burst_clap1", outs(), 5'b10_001);
        send_frame(0);
        expect_now("late_burst_gap", outs(), 5'b10_010);
        quiet_frames(GMAX);

        // Long burst.
        for (int i = 0; i < CMAX; i++) send_frame(200);
        expect_now("burst_at_max", outs(), 5'b10_001);
        send_frame(200);
        expect_now("long_burst_noise", outs(), 5'b10_101);
        quiet_frames(2);
        expect_now("long_burst_still_noise", outs(), 5'b10_101);
        quiet_frames(1);
        expect_now("long_burst_idle", outs(), 5'b10_000);

        // Holdoff: the second double clap inside holdoff is ignored.
        double_clap();
        expect_now("holdoff_first", outs(), 5'b01_100);
        double_clap();
        expect_now("holdoff_ignored", outs(), 5'b00_100);
        quiet_frames(HOLD - 10 - 1);
        expect_now("holdoff_last_frame", outs(), 5'b00_100);
        quiet_frames(1);
        expect_now("holdoff_exit", outs(), 5'b00_000);
        double_clap();
        expect_now("third_clap", outs(), 5'b11_100);
        quiet_frames(HOLD);

        // Reset while in CLAP2.
        send_frame(200); send_frame(0); send_frame(0); send_frame(0); send_frame(200);
        expect_now("in_clap2", outs(), 5'b10_011);
        idle_cycles(1);
        #2 reset = 1'b1;
        model_reset();
        #1 expect_now("async_reset", outs(), 5'b00_000);
        @(negedge clock);
        reset = 1'b0;
        @(negedge clock);
        double_clap();
        expect_now("clap_after_reset", outs(), 5'b11_100);
        quiet_frames(HOLD);

        // Randomized bursts and gaps, biased to land near the limits.
        for (int b = 0; b < 60; b++) begin
            int loud_n, quiet_n;
            loud_n = $urandom_range(1, CMAX + 1);
            case ($urandom_range(0, 3))
                0:       quiet_n = $urandom_range(1, GMIN + 1);
                1:       quiet_n = $urandom_range(GMAX - 1, GMAX + 2);
                default: quiet_n = $urandom_range(1, 12);
            endcase
            send_pattern(loud_n, quiet_n);
        end
        idle_cycles(2);

        // Drain with a bounded wait.
        wait_cycles = 0;
        while (exp_q.size() != 0 && wait_cycles < 20) begin
            @(negedge clock);
            wait_cycles++;
        end
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain_timeout: got %0d pending want 0", exp_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/clap_detector.md
Name: clap_detector

Overview:
- Consumes the per-window energy values produced by the SPI sample and energy stage.
- Recognises a "clap-clap" pattern: two short loud bursts separated by a bounded quiet gap.
- On recognition, toggles the light state that drives toglite_state at the top2 level.
- All timing is counted in energy frames, i.e. energy_ready pulses, never in raw clock cycles.

Parameters:
- ENERGY_WIDTH, 32, width of the unsigned energy value.
- THRESHOLD, 32'h0010_0000, loud level. A frame is loud when energy >= THRESHOLD (unsigned compare).
- CLAP_MAX_FRAMES, 6, maximum consecutive loud frames that still count as one clap.
- MIN_GAP_FRAMES, 3, minimum quiet frames required between the two claps.
- MAX_GAP_FRAMES, 40, maximum quiet frames allowed between the two claps.
- HOLDOFF_FRAMES, 64, frames ignored after a toggle.
- Counter width is clogb2 of the largest frame parameter. CNT_W = clogb2(HOLDOFF_FRAMES).

Ports:
- clock, input, 1, system clock.
- reset, input, 1, asynchronous, active-high reset.
- energy, input, ENERGY_WIDTH, energy of the latest window. Valid only while energy_ready = 1.
- energy_ready, input, 1, single-cycle strobe marking one new frame.
- toglite_state, output, 1, light state. Registered.
- toggle_pulse, output, 1, one-cycle pulse issued when the light toggles.
- detector_state, output, 3, current FSM state, for debug and LEDs.

Behaviour:
- Reset values: FSM = IDLE, all counters 0, toglite_state = 0, toggle_pulse = 0, detector_state = 3'd0.
- Reset is asynchronous and fully abortive at any point, including mid-pattern.
- FSM, counters and outputs change only on clock edges where energy_ready = 1. toggle_pulse is the exception: it clears on the next cycle.
- loud = (energy >= THRESHOLD). quiet = !loud.
- State encodings: IDLE = 0, CLAP1 = 1, GAP = 2, CLAP2 = 3, HOLDOFF = 4, NOISE = 5.
- IDLE:
  - loud -> CLAP1, len = 1.
  - quiet -> stay.
- CLAP1:
  - loud, len < CLAP_MAX_FRAMES -> len++.
  - loud, len == CLAP_MAX_FRAMES -> NOISE, qcnt = 0.
  - quiet -> GAP, gap = 1.
- GAP:
  - quiet, gap < MAX_GAP_FRAMES -> gap++.
  - quiet, gap == MAX_GAP_FRAMES -> IDLE.
  - loud, gap >= MIN_GAP_FRAMES -> CLAP2, len = 1.
  - loud, gap < MIN_GAP_FRAMES -> NOISE, qcnt = 0.
- CLAP2:
  - loud, len < CLAP_MAX_FRAMES -> len++.
  - loud, len == CLAP_MAX_FRAMES -> NOISE, qcnt = 0.
  - quiet -> HOLDOFF, hcnt = 0. On the same edge toglite_state inverts and toggle_pulse = 1 for exactly one cycle.
- HOLDOFF:
  - Every frame: hcnt++.
  - When hcnt reaches HOLDOFF_FRAMES-1 on a frame: quiet -> IDLE, loud -> NOISE with qcnt = 0.
- NOISE:
  - quiet -> qcnt++.
  - loud -> qcnt = 0.
  - When qcnt reaches MIN_GAP_FRAMES -> IDLE.
- Latency: toggle_pulse and the toglite_state change appear on the edge that samples the first quiet frame after clap 2. The outputs are visible the following cycle.
- energy_ready held high for consecutive cycles: each cycle is treated as a separate frame. This is legal.
- Counters never wrap. The FSM guarantees they stop at their parameter limits.
- energy_ready = 0: all state holds, including for arbitrarily long idle periods.

Decomposition:
- Shared include file clap_defs.vh holds:
  - the state encodings (localparams),
  - the clogb2 function,
  - default THRESHOLD and frame-count constants, shared with top2 and the energy stage.
- One sub-module, frame_counter, shared by the len, gap, hcnt and qcnt instances. Its controls are:
  - clear,
  - load to 1,
  - increment on energy_ready,
  - terminal-count compare against a port value.

Test Plan (THRESHOLD = 100, defaults otherwise; each listed value is one energy_ready frame):
- Double clap: 0,0,200,200,0,0,0,0,200,0 -> toggle_pulse on the final frame. toglite_state goes 0->1. detector_state goes to 4.
- Gap too short: 200,0,200,0 -> NOISE (5) on the third frame. No toggle. IDLE after 3 quiet frames.
- Gap timeout: 200, then 41 quiet frames, then 200,0 -> IDLE after quiet frame 40. The later burst only enters CLAP1. No toggle.
- Long burst: 7 consecutive frames of 200 -> NOISE on the 7th frame. No toggle until 3 quiet frames, then IDLE.
- Holdoff: double clap, then an immediate second double clap within 64 frames -> exactly one toggle. A third double clap after holdoff -> toglite_state returns to 0.
- Reset mid-pattern: assert reset asynchronously while in CLAP2 -> all outputs 0 immediately, detector_state = 0. After release a fresh double clap toggles normally.
